// File: rtl/cntr_mon.sv
`default_nettype none
// cntr_mon: watches a 4-bit bit-blasted counter bus, locks onto the +1 sequence,
// pulses err on breaks while locked, and counts wraps and saturating errors.
module cntr_mon #(
  parameter int LOCK_N = 3
) (
  input  logic c,
  input  logic rn,
  input  logic i_3_,
  input  logic i_2_,
  input  logic i_1_,
  input  logic i_0_,
  output logic lock,
  output logic err,
  output logic wrap_3_,
  output logic wrap_2_,
  output logic wrap_1_,
  output logic wrap_0_,
  output logic ecnt_3_,
  output logic ecnt_2_,
  output logic ecnt_1_,
  output logic ecnt_0_
);

  typedef enum logic [1:0] {
    UNSYNC = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_e;

  localparam logic [3:0] LOCK_V = 4'(LOCK_N);

  state_e     state_q, state_d;
  logic [3:0] prev_q;
  logic [3:0] run_q, run_d;
  logic [3:0] wrap_q, wrap_d;
  logic [3:0] ecnt_q, ecnt_d;
  logic       lock_q, lock_d;
  logic       err_q, err_d;

  logic [3:0] sample;
  logic [3:0] prev_inc;
  logic [3:0] run_inc;
  logic       good;

  assign sample   = {i_3_, i_2_, i_1_, i_0_};
  // 4-bit increment so 15 -> 0 counts as a good step
  assign prev_inc = prev_q + 4'd1;
  assign run_inc  = run_q + 4'd1;
  assign good     = (sample == prev_inc);

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    lock_d  = lock_q;
    err_d   = 1'b0;
    wrap_d  = wrap_q;
    ecnt_d  = ecnt_q;
    case (state_q)
      UNSYNC: begin
        run_d   = 4'd0;
        state_d = ACQ;
      end
      ACQ: begin
        if (good) begin
          if (run_inc == LOCK_V) begin
            state_d = LOCKED;
            lock_d  = 1'b1;
            run_d   = 4'd0;
          end else begin
            run_d = run_inc;
          end
        end else begin
          run_d = 4'd0;
        end
      end
      LOCKED: begin
        if (good) begin
          if (sample == 4'd0) wrap_d = wrap_q + 4'd1;
        end else begin
          err_d   = 1'b1;
          if (ecnt_q != 4'hF) ecnt_d = ecnt_q + 4'd1;
          lock_d  = 1'b0;
          run_d   = 4'd0;
          state_d = ACQ;
        end
      end
      default: begin
        state_d = UNSYNC;
        run_d   = 4'd0;
        lock_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge c or negedge rn) begin
    if (!rn) begin
      state_q <= UNSYNC;
      prev_q  <= 4'd0;
      run_q   <= 4'd0;
      wrap_q  <= 4'd0;
      ecnt_q  <= 4'd0;
      lock_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= sample;
      run_q   <= run_d;
      wrap_q  <= wrap_d;
      ecnt_q  <= ecnt_d;
      lock_q  <= lock_d;
      err_q   <= err_d;
    end
  end

  assign lock = lock_q;
  assign err  = err_q;
  assign {wrap_3_, wrap_2_, wrap_1_, wrap_0_} = wrap_q;
  assign {ecnt_3_, ecnt_2_, ecnt_1_, ecnt_0_} = ecnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cntr_mon.sv
`default_nettype none
// tb_cntr_mon: directed scoreboard bench; dut uses LOCK_N=3 on a driven bus,
// dut1 uses LOCK_N=1 fed by a live free-running counter.
module tb_cntr_mon;

  logic       c = 1'b0;
  logic       rn = 1'b0;
  logic       rn1 = 1'b0;
  logic [3:0] bus = 4'd0;
  logic [3:0] cnt;

  logic       lock0, err0, lock1, err1;
  logic [3:0] wrap0, ecnt0, wrap1, ecnt1;

  typedef struct {
    bit         sel;
    logic       lock;
    logic       err;
    logic [3:0] wrap;
    logic [3:0] ecnt;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  always #5 c = ~c;

  always @(posedge c or negedge rn1) begin
    if (!rn1) cnt <= 4'd0;
    else      cnt <= cnt + 4'd1;
  end

  cntr_mon #(.LOCK_N(3)) dut (
    .c(c), .rn(rn),
    .i_3_(bus[3]), .i_2_(bus[2]), .i_1_(bus[1]), .i_0_(bus[0]),
    .lock(lock0), .err(err0),
    .wrap_3_(wrap0[3]), .wrap_2_(wrap0[2]), .wrap_1_(wrap0[1]), .wrap_0_(wrap0[0]),
    .ecnt_3_(ecnt0[3]), .ecnt_2_(ecnt0[2]), .ecnt_1_(ecnt0[1]), .ecnt_0_(ecnt0[0])
  );

  cntr_mon #(.LOCK_N(1)) dut1 (
    .c(c), .rn(rn1),
    .i_3_(cnt[3]), .i_2_(cnt[2]), .i_1_(cnt[1]), .i_0_(cnt[0]),
    .lock(lock1), .err(err1),
    .wrap_3_(wrap1[3]), .wrap_2_(wrap1[2]), .wrap_1_(wrap1[1]), .wrap_0_(wrap1[0]),
    .ecnt_3_(ecnt1[3]), .ecnt_2_(ecnt1[2]), .ecnt_1_(ecnt1[1]), .ecnt_0_(ecnt1[0])
  );

  task automatic check(input string tag, input logic [9:0] act, input logic [9:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got lock/err/wrap/ecnt=%b/%b/%0d/%0d want %b/%b/%0d/%0d",
               tag, act[9], act[8], act[7:4], act[3:0], req[9], req[8], req[7:4], req[3:0]);
    end
  endtask

  // One pop per clock: the entry pushed before this edge describes the outputs after it
  always @(posedge c) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (e.sel)
        check(e.tag, {lock1, err1, wrap1, ecnt1}, {e.lock, e.err, e.wrap, e.ecnt});
      else
        check(e.tag, {lock0, err0, wrap0, ecnt0}, {e.lock, e.err, e.wrap, e.ecnt});
    end
  end

  task automatic push(input bit sel, input logic l, input logic e,
                      input logic [3:0] w, input logic [3:0] ec, input string tag);
    exp_t x;
    x.sel = sel; x.lock = l; x.err = e; x.wrap = w; x.ecnt = ec; x.tag = tag;
    sb.push_back(x);
  endtask

  task automatic step(input logic [3:0] s, input logic l, input logic e,
                      input logic [3:0] w, input logic [3:0] ec, input string tag);
    @(negedge c);
    bus = s;
    push(1'b0, l, e, w, ec, tag);
    @(posedge c);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] v;
    logic [3:0] ec;

    repeat (2) @(negedge c);
    check("reset_state", {lock0, err0, wrap0, ecnt0}, 10'd0);
    rn = 1'b1;

    // acquisition: edge 1 UNSYNC, samples 1,2,3 are the three good steps
    step(4'd0, 0, 0, 0, 0, "acq_e1");
    step(4'd1, 0, 0, 0, 0, "acq_e2");
    step(4'd2, 0, 0, 0, 0, "acq_e3");
    step(4'd3, 1, 0, 0, 0, "acq_lock");
    step(4'd4, 1, 0, 0, 0, "locked_4");

    // two wraps while locked
    for (int i = 5; i <= 15; i++) step(4'(i), 1, 0, 0, 0, "wrapA");
    step(4'd0, 1, 0, 1, 0, "wrap1");
    for (int i = 1; i <= 15; i++) step(4'(i), 1, 0, 1, 0, "wrapB");
    step(4'd0, 1, 0, 2, 0, "wrap2");

    // single break 7 -> 9, relock on 10,11,12
    for (int i = 1; i <= 7; i++) step(4'(i), 1, 0, 2, 0, "pre_break");
    step(4'd9,  0, 1, 2, 1, "break_err");
    step(4'd10, 0, 0, 2, 1, "err_clear");
    step(4'd11, 0, 0, 2, 1, "reacq");
    step(4'd12, 1, 0, 2, 1, "relock");

    // stuck bus at 4
    step(4'd13, 1, 0, 2, 1, "run13");
    step(4'd14, 1, 0, 2, 1, "run14");
    step(4'd15, 1, 0, 2, 1, "run15");
    step(4'd0,  1, 0, 3, 1, "wrap3");
    for (int i = 1; i <= 4; i++) step(4'(i), 1, 0, 3, 1, "run_to4");
    step(4'd4, 0, 1, 3, 2, "stuck_err");

    // 20 lock/break cycles; the lock-completing sample is sometimes 0 and must not count as a wrap
    v = 4'd4;
    ec = 4'd2;
    for (int k = 0; k < 20; k++) begin
      step(v + 4'd1, 0, 0, 3, ec, "sat_acq1");
      step(v + 4'd2, 0, 0, 3, ec, "sat_acq2");
      step(v + 4'd3, 1, 0, 3, ec, "sat_lock");
      if (ec != 4'hF) ec = ec + 4'd1;
      step(v + 4'd3, 0, 1, 3, ec, "sat_break");
      v = v + 4'd3;
    end
    step(4'd3, 0, 0, 3, 15, "noise3");

    // acquire noise: run restarts at 9
    step(4'd4,  0, 0, 3, 15, "noise4");
    step(4'd9,  0, 0, 3, 15, "noise9");
    step(4'd10, 0, 0, 3, 15, "noise10");
    step(4'd11, 0, 0, 3, 15, "noise11");
    step(4'd12, 1, 0, 3, 15, "noise_lock");
    for (int i = 13; i <= 15; i++) step(4'(i), 1, 0, 3, 15, "to_wrap4");
    step(4'd0, 1, 0, 4, 15, "wrap4");
    for (int i = 1; i <= 15; i++) step(4'(i), 1, 0, 4, 15, "to_wrap5");
    step(4'd0, 1, 0, 5, 15, "wrap5");

    // asynchronous reset mid-cycle while locked
    @(posedge c);
    #2 rn = 1'b0;
    #1 check("async_reset", {lock0, err0, wrap0, ecnt0}, 10'd0);
    @(negedge c);
    rn = 1'b1;
    step(4'd5, 0, 0, 0, 0, "post_rst_unsync");
    step(4'd6, 0, 0, 0, 0, "post_rst_r1");
    step(4'd7, 0, 0, 0, 0, "post_rst_r2");
    step(4'd8, 1, 0, 0, 0, "post_rst_lock");

    // live counter into LOCK_N=1: edge k samples k-1, 15->0 seen at edges 17,33,...,97
    @(negedge c);
    rn1 = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      if (k == 1)        push(1'b1, 0, 0, 0, 0, "live_e1");
      else if (k == 2)   push(1'b1, 1, 0, 0, 0, "live_lock");
      else if (k == 17)  push(1'b1, 1, 0, 1, 0, "live_wrap1");
      else if (k == 100) push(1'b1, 1, 0, 6, 0, "live_end");
      @(posedge c);
      @(negedge c);
    end

    @(negedge c);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
